// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle fetch/execute/memory/commit sequencer with
//               valid/ready memory handshakes. Optional memory watchdog is
//               enabled by defining SEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter logic [31:0] RESET_INST     = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] pc,
    output logic             imem_req_valid,
    input  wire logic        imem_req_ready,
    output logic [31:0]      imem_addr,
    input  wire logic        imem_rsp_valid,
    input  wire logic [31:0] imem_rsp_data,
    output logic [31:0]      inst,
    input  wire logic        is_mem,
    input  wire logic        is_store,
    input  wire logic        is_ebreak,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  wire logic        dmem_req_ready,
    input  wire logic        dmem_rsp_valid,
    output logic             commit,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [31:0]      retired
);

    localparam logic [2:0] c_FETCH_REQ  = 3'd0;
    localparam logic [2:0] c_FETCH_WAIT = 3'd1;
    localparam logic [2:0] c_EXEC       = 3'd2;
    localparam logic [2:0] c_MEM_REQ    = 3'd3;
    localparam logic [2:0] c_MEM_WAIT   = 3'd4;
    localparam logic [2:0] c_COMMIT     = 3'd5;
    localparam logic [2:0] c_HALT       = 3'd6;

    localparam logic [1:0] c_CAUSE_EBREAK  = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_inst;
    logic [31:0] r_retired;
    logic [1:0]  r_halt_cause;
    logic        w_timeout;

`ifdef SEQ_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_count;
    logic              w_wd_watched;

    assign w_wd_watched = (r_state == c_FETCH_REQ) || (r_state == c_FETCH_WAIT) ||
                          (r_state == c_MEM_REQ)   || (r_state == c_MEM_WAIT);
    // Fires on the TIMEOUT_CYCLES-th cycle spent in a waiting state.
    assign w_timeout    = w_wd_watched && (r_wd_count == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_count <= '0;
        end else if (w_next_state != r_state) begin
            r_wd_count <= '0;
        end else if (w_wd_watched) begin
            r_wd_count <= r_wd_count + 1'b1;
        end
    end
`else
    // Without the watchdog the sequencer waits on memory indefinitely.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Handshakes are tested before the timeout so a same-cycle handshake wins.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH_REQ: begin
                if (imem_req_ready)      w_next_state = c_FETCH_WAIT;
                else if (w_timeout)      w_next_state = c_HALT;
            end
            c_FETCH_WAIT: begin
                if (imem_rsp_valid)      w_next_state = c_EXEC;
                else if (w_timeout)      w_next_state = c_HALT;
            end
            c_EXEC: begin
                if (is_ebreak)           w_next_state = c_HALT;
                else if (is_mem)         w_next_state = c_MEM_REQ;
                else                     w_next_state = c_COMMIT;
            end
            c_MEM_REQ: begin
                if (dmem_req_ready)      w_next_state = c_MEM_WAIT;
                else if (w_timeout)      w_next_state = c_HALT;
            end
            c_MEM_WAIT: begin
                if (dmem_rsp_valid)      w_next_state = c_COMMIT;
                else if (w_timeout)      w_next_state = c_HALT;
            end
            c_COMMIT:                    w_next_state = c_FETCH_REQ;
            c_HALT:                      w_next_state = c_HALT;
            default:                     w_next_state = c_FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_FETCH_REQ;
            r_inst       <= RESET_INST;
            r_retired    <= '0;
            r_halt_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_FETCH_WAIT) && imem_rsp_valid) begin
                r_inst <= imem_rsp_data;
            end
            if (r_state == c_COMMIT) begin
                r_retired <= r_retired + 32'd1;
            end
            if ((w_next_state == c_HALT) && (r_state != c_HALT)) begin
                r_halt_cause <= (r_state == c_EXEC) ? c_CAUSE_EBREAK : c_CAUSE_TIMEOUT;
            end
        end
    end

    assign imem_req_valid = (r_state == c_FETCH_REQ);
    assign imem_addr      = pc;
    assign dmem_req_valid = (r_state == c_MEM_REQ);
    assign dmem_req_we    = (r_state == c_MEM_REQ) && is_store;
    assign commit         = (r_state == c_COMMIT);
    assign halted         = (r_state == c_HALT);
    assign halt_cause     = r_halt_cause;
    assign retired        = r_retired;
    assign inst           = r_inst;

endmodule
`default_nettype wire
